// File: rtl/lfsr_pkg.sv
// Shared types and constants for the XNOR LFSR stream generator family.
// lfsr_max_taps() gives the xapp052 maximal-length XNOR tap mask for a width.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } lfsr_state_t;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  // Bit k set means stage k+1 feeds back.
  function automatic logic [31:0] lfsr_max_taps(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_period_cnt.sv
// Saturating step counter: flags the step that lands back on the seed
// and publishes the length of the cycle just completed.
module lfsr_period_cnt
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                clear,
  input  logic                step,
  input  logic [NUM_BITS-1:0] next_state,
  input  logic [NUM_BITS-1:0] seed,
  output logic                wrap,
  output logic [NUM_BITS-1:0] period
);

  localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] cnt_reg;
  logic [NUM_BITS-1:0] cnt_inc;

  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + ONE;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      cnt_reg <= '0;
      wrap    <= 1'b0;
      period  <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
      wrap    <= 1'b0;
    end else if (step && (next_state == seed)) begin
      wrap    <= 1'b1;
      period  <= cnt_inc;
      cnt_reg <= '0;
    end else begin
      wrap <= 1'b0;
      if (step) cnt_reg <= cnt_inc;
    end
  end

endmodule

// File: rtl/lfsr_stream_gen.sv
// XNOR-feedback LFSR with loadable taps/seed, valid/ready stream and lock-up FSM.
// Define LFSR_AUTO_RECOVER_EN to reseed automatically one cycle after lock-up.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS     = 16,
  parameter logic [NUM_BITS-1:0] DEFAULT_TAPS = 16'hD008
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Load,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic                i_Taps_Load,
  input  logic [NUM_BITS-1:0] i_Taps,
  input  logic                i_Enable,
  input  logic                i_Ready,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_Valid,
  output logic                o_Wrap,
  output logic [NUM_BITS-1:0] o_Period,
  output logic                o_Lockup
);

  generate
    if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
      $error("lfsr_stream_gen: NUM_BITS must be within 3..32");
    end
  endgenerate

  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  lfsr_state_t         fsm_reg;
  logic [NUM_BITS-1:0] state_reg;
  logic [NUM_BITS-1:0] taps_reg;
  logic [NUM_BITS-1:0] step_next;
  logic [NUM_BITS-1:0] recover_seed;
  logic                valid_reg;
  logic                lockup_reg;
  logic                fb;
  logic                step_en;
  logic                recover;

  assign fb        = ~^(state_reg & taps_reg);
  assign step_next = {state_reg[NUM_BITS-2:0], fb};
  assign step_en   = (fsm_reg == RUN) && i_Ready && i_Enable && !i_Load;

`ifdef LFSR_AUTO_RECOVER_EN
  // An all-ones seed would relock immediately, so knock out bit 0.
  assign recover      = (fsm_reg == LOCK) && !i_Load;
  assign recover_seed = (i_Seed_Data == ALL_ONES) ? {i_Seed_Data[NUM_BITS-1:1], 1'b0}
                                                  : i_Seed_Data;
`else
  assign recover      = 1'b0;
  assign recover_seed = i_Seed_Data;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_reg  <= i_Seed_Data;
      taps_reg   <= DEFAULT_TAPS;
      fsm_reg    <= IDLE;
      valid_reg  <= 1'b0;
      lockup_reg <= 1'b0;
    end else begin
      // The step below still sees the old taps_reg on a capture cycle.
      if (i_Taps_Load) taps_reg <= i_Taps;

      if (i_Load) begin
        state_reg <= i_Seed_Data;
        if (i_Seed_Data == ALL_ONES) begin
          fsm_reg    <= LOCK;
          valid_reg  <= 1'b0;
          lockup_reg <= 1'b1;
        end else begin
          fsm_reg    <= i_Enable ? RUN : IDLE;
          valid_reg  <= i_Enable;
          lockup_reg <= 1'b0;
        end
      end else begin
        case (fsm_reg)
          IDLE: begin
            if (i_Enable) begin
              if (state_reg == ALL_ONES) begin
                fsm_reg    <= LOCK;
                lockup_reg <= 1'b1;
              end else begin
                fsm_reg   <= RUN;
                valid_reg <= 1'b1;
              end
            end
          end
          RUN: begin
            if (!i_Enable) begin
              fsm_reg   <= IDLE;
              valid_reg <= 1'b0;
            end else if (i_Ready) begin
              state_reg <= step_next;
              if (step_next == ALL_ONES) begin
                fsm_reg    <= LOCK;
                valid_reg  <= 1'b0;
                lockup_reg <= 1'b1;
              end
            end
          end
          LOCK: begin
            if (recover) begin
              state_reg  <= recover_seed;
              fsm_reg    <= i_Enable ? RUN : IDLE;
              valid_reg  <= i_Enable;
              lockup_reg <= 1'b0;
            end
          end
          default: begin
            fsm_reg    <= IDLE;
            valid_reg  <= 1'b0;
            lockup_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  lfsr_period_cnt #(
    .NUM_BITS(NUM_BITS)
  ) u_period_cnt (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .clear     (i_Load | recover),
    .step      (step_en),
    .next_state(step_next),
    .seed      (i_Seed_Data),
    .wrap      (o_Wrap),
    .period    (o_Period)
  );

  assign o_LFSR_Data = state_reg;
  assign o_Valid     = valid_reg;
  assign o_Lockup    = lockup_reg;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench for lfsr_stream_gen at NUM_BITS=4: fixed vector tables,
// hand-written corner sequences and a randomized run against a behavioural model.
module tb_lfsr_stream_gen;

  localparam int N = 4;

  logic         i_Clk = 1'b0;
  logic         i_Rst = 1'b0;
  logic         i_Load = 1'b0;
  logic [N-1:0] i_Seed_Data = '0;
  logic         i_Taps_Load = 1'b0;
  logic [N-1:0] i_Taps = '0;
  logic         i_Enable = 1'b0;
  logic         i_Ready = 1'b0;
  logic [N-1:0] o_LFSR_Data;
  logic         o_Valid;
  logic         o_Wrap;
  logic [N-1:0] o_Period;
  logic         o_Lockup;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: mode 0=idle, 1=run, 2=locked.
  int m_state, m_taps, m_cnt, m_period, m_mode;
  bit m_wrap;

  typedef struct {
    logic [N-1:0] data;
    logic         wrap;
  } vec_t;
  vec_t seq_tbl[15];
  logic [N-1:0] zero_tap_tbl[4];

  lfsr_stream_gen #(
    .NUM_BITS    (N),
    .DEFAULT_TAPS(4'hC)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (i_Load),
    .i_Seed_Data(i_Seed_Data),
    .i_Taps_Load(i_Taps_Load),
    .i_Taps     (i_Taps),
    .i_Enable   (i_Enable),
    .i_Ready    (i_Ready),
    .o_LFSR_Data(o_LFSR_Data),
    .o_Valid    (o_Valid),
    .o_Wrap     (o_Wrap),
    .o_Period   (o_Period),
    .o_Lockup   (o_Lockup)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    int old_taps, nxt;
    if (!i_Rst) begin
      m_state = i_Seed_Data; m_taps = 4'hC; m_cnt = 0; m_period = 0;
      m_wrap = 0; m_mode = 0;
      return;
    end
    old_taps = m_taps;
    if (i_Taps_Load) m_taps = i_Taps;
    m_wrap = 0;
    if (i_Load) begin
      m_state = i_Seed_Data;
      m_cnt   = 0;
      m_mode  = (i_Seed_Data == 15) ? 2 : (i_Enable ? 1 : 0);
    end else begin
      case (m_mode)
        0: if (i_Enable) m_mode = (m_state == 15) ? 2 : 1;
        1: begin
          if (!i_Enable) m_mode = 0;
          else if (i_Ready) begin
            // XNOR feedback is 1 when an even number of tapped stages are set.
            nxt = (m_state * 2) % 16 + ((($countones(m_state & old_taps) % 2) == 0) ? 1 : 0);
            m_state = nxt;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            if (nxt == int'(i_Seed_Data)) begin
              m_wrap = 1; m_period = m_cnt; m_cnt = 0;
            end
            if (nxt == 15) m_mode = 2;
          end
        end
        default: begin
`ifdef LFSR_AUTO_RECOVER_EN
          m_state = (i_Seed_Data == 15) ? 14 : int'(i_Seed_Data);
          m_cnt   = 0;
          m_mode  = i_Enable ? 1 : 0;
`endif
        end
      endcase
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge i_Clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%b ld=%b seed=%h en=%b rdy=%b | data=%h valid=%b wrap=%b period=%0d lockup=%b",
             cyc, i_Rst, i_Load, i_Seed_Data, i_Enable, i_Ready,
             o_LFSR_Data, o_Valid, o_Wrap, o_Period, o_Lockup);
    chk("data",   o_LFSR_Data, m_state);
    chk("valid",  o_Valid,     m_mode == 1);
    chk("wrap",   o_Wrap,      m_wrap);
    chk("period", o_Period,    m_period);
    chk("lockup", o_Lockup,    m_mode == 2);
  endtask

  task automatic load_seed(input logic [N-1:0] seed);
    i_Load = 1'b1; i_Seed_Data = seed;
    cycle();
    i_Load = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq_vals[15];
    seq_vals = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    for (int i = 0; i < 15; i++) begin
      seq_tbl[i].data = seq_vals[i];
      seq_tbl[i].wrap = (i == 14);
    end
    zero_tap_tbl = '{4'h1, 4'h3, 4'h7, 4'hF};

    // Reset values
    i_Rst = 1'b0; i_Seed_Data = 4'h0;
    cycle();
    chk("rst_data", o_LFSR_Data, 4'h0);
    chk("rst_valid", o_Valid, 1'b0);
    chk("rst_period", o_Period, 4'h0);
    chk("rst_lockup", o_Lockup, 1'b0);

    // Enable from idle: valid rises one cycle later, then the maximal sequence
    i_Rst = 1'b1; i_Enable = 1'b1; i_Ready = 1'b1;
    cycle();
    chk("valid_rise", o_Valid, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("seq_data", o_LFSR_Data, seq_tbl[i].data);
      chk("seq_wrap", o_Wrap, seq_tbl[i].wrap);
    end
    chk("seq_period", o_Period, 4'd15);

    // Ready toggling: every other cycle holds, wrap lands on cycle 30
    load_seed(4'h0);
    for (int c = 1; c <= 30; c++) begin
      i_Ready = (c % 2 == 0);
      cycle();
      chk("toggle_wrap", o_Wrap, c == 30);
    end
    chk("toggle_period", o_Period, 4'd15);
    i_Ready = 1'b1;

    // All-ones seed locks, a normal seed releases
    load_seed(4'hF);
    chk("lock_lockup", o_Lockup, 1'b1);
    chk("lock_valid", o_Valid, 1'b0);
    cycle();
`ifdef LFSR_AUTO_RECOVER_EN
    chk("recover_data", o_LFSR_Data, 4'hE);
    chk("recover_lockup", o_Lockup, 1'b0);
`else
    chk("lock_hold", o_Lockup, 1'b1);
`endif
    load_seed(4'h5);
    chk("unlock_valid", o_Valid, 1'b1);
    chk("unlock_lockup", o_Lockup, 1'b0);
    chk("unlock_data", o_LFSR_Data, 4'h5);

    // Zero tap mask climbs to all-ones
    i_Taps_Load = 1'b1; i_Taps = 4'h0;
    load_seed(4'h0);
    i_Taps_Load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("zero_tap_data", o_LFSR_Data, zero_tap_tbl[i]);
    end
    chk("zero_tap_lock", o_Lockup, 1'b1);
    cycle();
`ifdef LFSR_AUTO_RECOVER_EN
    chk("zero_tap_reload", o_LFSR_Data, 4'h0);
`else
    chk("zero_tap_hold", o_LFSR_Data, 4'hF);
`endif

    // Tap capture on a step cycle uses the old taps for that step
    i_Taps_Load = 1'b1; i_Taps = 4'hC;
    load_seed(4'h0);
    i_Taps_Load = 1'b0;
    repeat (3) cycle();
    chk("taps_pre", o_LFSR_Data, 4'h7);
    i_Taps_Load = 1'b1; i_Taps = 4'h9;
    cycle();
    i_Taps_Load = 1'b0;
    chk("taps_old", o_LFSR_Data, 4'hE);
    cycle();
    chk("taps_new", o_LFSR_Data, 4'hC);

    // Reset mid-run
    i_Taps_Load = 1'b1; i_Taps = 4'hC;
    load_seed(4'h0);
    i_Taps_Load = 1'b0;
    repeat (3) cycle();
    i_Seed_Data = 4'h2; i_Rst = 1'b0;
    cycle();
    chk("midrst_data", o_LFSR_Data, 4'h2);
    chk("midrst_valid", o_Valid, 1'b0);
    chk("midrst_period", o_Period, 4'h0);
    i_Rst = 1'b1;

    // Randomized traffic against the model
    load_seed(4'h3);
    for (int k = 0; k < 600; k++) begin
      i_Enable    = ($urandom_range(0, 9) != 0);
      i_Ready     = ($urandom_range(0, 2) != 0);
      i_Load      = ($urandom_range(0, 24) == 0);
      if (i_Load) i_Seed_Data = 4'($urandom_range(0, 15));
      i_Taps_Load = ($urandom_range(0, 29) == 0);
      i_Taps      = 4'($urandom_range(0, 15));
      i_Rst       = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
